// File: rtl/suma_pkg.sv
// Shared definitions for the multicycle two's-complement adder:
// FSM state encoding and default slice geometry.
package suma_pkg;

    localparam int ANCHO_DEF = 64;
    localparam int NSEG_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUMA  = 2'd1,
        LISTO = 2'd2
    } estado_t;

endpackage

// File: rtl/suma_c2_slice.sv
// One ANCHO-bit adder slice with carry in; also exposes the carry into its MSB
// so the caller can derive signed overflow on the final slice.
module suma_c2_slice #(
    parameter int ANCHO = 64
) (
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    input  logic             ci,
    output logic [ANCHO-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{ANCHO{1'b0}}, ci};

    // Sum bit = a ^ b ^ carry_in, so the MSB carry-in falls out of the sum bit.
    assign c_msb = a[ANCHO-1] ^ b[ANCHO-1] ^ s[ANCHO-1];

endmodule

// File: rtl/suma_multiciclo.sv
// Multicycle W-bit add/subtract, one ANCHO-bit slice per clock, LSB slice first.
// Optional zero flag output enabled with macro SUMA_MULTICICLO_CERO_EN.
module suma_multiciclo
    import suma_pkg::*;
#(
    parameter  int ANCHO = ANCHO_DEF,
    parameter  int NSEG  = NSEG_DEF,
    localparam int W     = ANCHO * NSEG
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         resta,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         desborde
`ifdef SUMA_MULTICICLO_CERO_EN
   ,output logic         cero
`endif
);

    localparam int CW = (NSEG > 1) ? $clog2(NSEG) : 1;

    estado_t estado, estado_sig;

    logic [W-1:0]       a_r, b_r, s_r;
    logic [CW-1:0]      cnt;
    logic               carry_r, cout_r, desb_r;
    logic               acepta, ultimo;
    logic [ANCHO-1:0]   sl_s;
    logic               sl_cout, sl_cmsb;
    logic [W+ANCHO-1:0] s_cat;

    assign ultimo = (cnt == CW'(NSEG - 1));

    // Operands shift down one slice per cycle, so the slice always sees bits [ANCHO-1:0].
    suma_c2_slice #(.ANCHO(ANCHO)) u_slice (
        .a     (a_r[ANCHO-1:0]),
        .b     (b_r[ANCHO-1:0]),
        .ci    (carry_r),
        .s     (sl_s),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    // New slice enters at the top; after NSEG cycles the result is fully aligned.
    assign s_cat = {sl_s, s_r};

    always_ff @(posedge clk) begin
        if (rst) estado <= IDLE;
        else     estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        acepta     = 1'b0;
        case (estado)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acepta     = 1'b1;
                    estado_sig = SUMA;
                end
            end
            SUMA: begin
                if (ultimo) estado_sig = LISTO;
            end
            LISTO: begin
                out_valid = 1'b1;
                if (out_ready) estado_sig = IDLE;
            end
            default: estado_sig = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            s_r     <= '0;
            cnt     <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            desb_r  <= 1'b0;
        end else if (acepta) begin
            a_r     <= a;
            b_r     <= resta ? ~b : b;
            carry_r <= resta;
            cnt     <= '0;
        end else if (estado == SUMA) begin
            a_r     <= a_r >> ANCHO;
            b_r     <= b_r >> ANCHO;
            s_r     <= s_cat[W+ANCHO-1:ANCHO];
            carry_r <= sl_cout;
            if (ultimo) begin
                cout_r <= sl_cout;
                desb_r <= sl_cout ^ sl_cmsb;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign s        = s_r;
    assign cout     = cout_r;
    assign desborde = desb_r;

`ifdef SUMA_MULTICICLO_CERO_EN
    // Zero flag accumulates one slice at a time; no wide reduction on the last cycle.
    logic cero_r;

    always_ff @(posedge clk) begin
        if (rst)                 cero_r <= 1'b0;
        else if (acepta)         cero_r <= 1'b1;
        else if (estado == SUMA) cero_r <= cero_r & ~|sl_s;
    end

    assign cero = (estado == LISTO) & cero_r;
`endif

endmodule
